// File: rtl/level_alarm_controller.sv
// rtl/level_alarm_controller.sv - BCD display value to scaled level, classified with hysteresis, persistence and latched alarm
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   number            DIGITS nibble-packed BCD digits, digit 0 rightmost, 0xF = blank
//   dp_list           one-hot units-digit marker (all-zero means digit 0)
//   btn0              asynchronous acknowledge button
//   state             0 IDLE, 1 NORMAL, 2 WARN, 3 ALARM, 4 LATCHED, 5 FAULT
//   value             last valid reading scaled by 10^FRAC
//   valid             one-cycle pulse when a frame has been classified
//   alarm             buzzer request
module level_alarm_controller #(
  parameter int DIGITS   = 8,
  parameter int FRAC     = 2,
  parameter int VAL_W    = 32,
  parameter int WARN_TH  = 50000,
  parameter int ALARM_TH = 100000,
  parameter int HYST     = 1000,
  parameter int PERSIST  = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp_list,
  input  logic                  btn0,
  output logic [2:0]            state,
  output logic [VAL_W-1:0]      value,
  output logic                  valid,
  output logic                  alarm
);

  localparam int F    = DIGITS + FRAC + 2;
  localparam int PH_W = $clog2(F);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int PC_W = $clog2(PERSIST + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(F - 1);
  localparam logic [VAL_W-1:0] VAL_MAX  = '1;
  localparam logic [VAL_W-1:0] ALARM_V  = VAL_W'(ALARM_TH);
  localparam logic [VAL_W-1:0] WARN_V   = VAL_W'(WARN_TH);
  localparam logic [VAL_W-1:0] ALARM_LO = VAL_W'(ALARM_TH - HYST);
  localparam logic [VAL_W-1:0] WARN_LO  = VAL_W'(WARN_TH - HYST);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_NORMAL  = 3'd1,
    S_WARN    = 3'd2,
    S_ALARM   = 3'd3,
    S_LATCHED = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  logic [PH_W-1:0]     phase_q, phase_d;
  logic [4*DIGITS-1:0] num_q, num_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [VAL_W-1:0]    acc_q, acc_d;
  state_t              state_q, state_d, last_t_q, last_t_d;
  logic [VAL_W-1:0]    value_q, value_d;
  logic                valid_q, valid_d, alarm_q, alarm_d;
  logic                silenced_q, silenced_d;
  logic [PC_W-1:0]     pcnt_q, pcnt_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                ack_q, ack_d;

  int                  k, dp_ones, pos;
  logic                seen, frame_bad, use_pos;
  logic [3:0]          nib, digit;
  logic [VAL_W+3:0]    prod;
  logic [VAL_W-1:0]    acc_next;

  // Frame validation, units position and one Horner step.
  always_comb begin
    k         = 0;
    dp_ones   = 0;
    seen      = 1'b0;
    frame_bad = 1'b0;
    nib       = 4'h0;
    digit     = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dp_q[i]) begin
        k       = i;
        dp_ones = dp_ones + 1;
      end
    end
    // Scan from the most significant digit: only leading blanks are legal.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = num_q[4*i +: 4];
      if (nib inside {[4'hA:4'hE]}) frame_bad = 1'b1;
      if (nib == 4'hF) begin
        if (seen || i == k) frame_bad = 1'b1;
      end else begin
        seen = 1'b1;
      end
    end
    if (!seen || dp_ones > 1) frame_bad = 1'b1;

    // ACCUM cycle j (1-based) handles digit position DIGITS-j.
    pos = DIGITS - int'(phase_q);
    for (int i = 0; i < DIGITS; i++) begin
      if (i == pos && num_q[4*i +: 4] != 4'hF) digit = num_q[4*i +: 4];
    end
    use_pos  = (pos >= k - FRAC);
    prod     = {4'b0, acc_q} * (VAL_W+4)'(10) + (VAL_W+4)'(digit);
    // Once clamped, acc*10 still exceeds the maximum, so it stays clamped.
    acc_next = (prod > {4'b0, VAL_MAX}) ? VAL_MAX : prod[VAL_W-1:0];
  end

  state_t st_eff, t;
  logic   sil_eff;
  logic [PC_W-1:0] pcnt_eff;

  always_comb begin
    phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    num_d    = num_q;
    dp_d     = dp_q;
    acc_d    = acc_q;
    if (phase_q == '0) begin
      num_d = number;
      dp_d  = dp_list;
      acc_d = '0;
    end else if (phase_q != PH_LAST && use_pos) begin
      acc_d = acc_next;
    end

    sync1_d  = btn0;
    sync2_d  = sync1_q;
    db_cnt_d = !sync2_q ? '0 :
               (db_cnt_q == DB_W'(DEBOUNCE)) ? db_cnt_q : db_cnt_q + 1'b1;
    ack_d    = sync2_q && (db_cnt_q == DB_W'(DEBOUNCE - 1));

    // Acknowledge is applied before any classification in the same cycle.
    st_eff   = state_q;
    sil_eff  = silenced_q;
    pcnt_eff = pcnt_q;
    if (ack_q) begin
      if (state_q == S_ALARM) begin
        sil_eff = 1'b1;
      end else if (state_q == S_LATCHED) begin
        st_eff   = last_t_q;
        pcnt_eff = '0;
      end
    end

    if (acc_q >= ALARM_V)     t = S_ALARM;
    else if (acc_q >= WARN_V) t = S_WARN;
    else                      t = S_NORMAL;
    if (st_eff == S_ALARM && acc_q >= ALARM_LO) t = S_ALARM;
    if (st_eff == S_WARN && t == S_NORMAL && acc_q >= WARN_LO) t = S_WARN;

    state_d    = st_eff;
    silenced_d = sil_eff;
    pcnt_d     = pcnt_eff;
    last_t_d   = last_t_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    if (phase_q == PH_LAST) begin
      valid_d = 1'b1;
      if (frame_bad) begin
        state_d = S_FAULT;
        pcnt_d  = '0;
      end else begin
        value_d  = acc_q;
        last_t_d = t;
        if (st_eff == S_IDLE || st_eff == S_FAULT) begin
          state_d    = t;
          silenced_d = 1'b0;
          pcnt_d     = '0;
        end else if (t == st_eff) begin
          pcnt_d = '0;
        end else begin
          // LATCHED never equals a class, so its count saturates while waiting.
          if (t != last_t_q)                     pcnt_d = PC_W'(1);
          else if (pcnt_eff != PC_W'(PERSIST))   pcnt_d = pcnt_eff + 1'b1;
          if (pcnt_d == PC_W'(PERSIST)) begin
            case (st_eff)
              S_ALARM:   state_d = sil_eff ? t : S_LATCHED;
              S_LATCHED: if (t == S_ALARM) state_d = S_ALARM;
              default:   state_d = t;
            endcase
            if (state_d != st_eff) pcnt_d = '0;
          end
        end
      end
    end
    if (state_d == S_ALARM && state_q != S_ALARM) silenced_d = 1'b0;
    alarm_d = (state_d == S_ALARM && !silenced_d) || state_d == S_LATCHED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      num_q      <= '0;
      dp_q       <= '0;
      acc_q      <= '0;
      state_q    <= S_IDLE;
      last_t_q   <= S_IDLE;
      value_q    <= '0;
      valid_q    <= 1'b0;
      alarm_q    <= 1'b0;
      silenced_q <= 1'b0;
      pcnt_q     <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      ack_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      num_q      <= num_d;
      dp_q       <= dp_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      last_t_q   <= last_t_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      alarm_q    <= alarm_d;
      silenced_q <= silenced_d;
      pcnt_q     <= pcnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      ack_q      <= ack_d;
    end
  end

  assign state = state_q;
  assign value = value_q;
  assign valid = valid_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_level_alarm_controller.sv
// tb/tb_level_alarm_controller.sv - directed self-checking bench for level_alarm_controller
module tb_level_alarm_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] number = 32'h0;
  logic [7:0]  dp_list = 8'h0;
  logic        btn0 = 1'b0;
  logic [2:0]  state;
  logic [31:0] value;
  logic        valid;
  logic        alarm;
  logic [2:0]  s_state;
  logic [23:0] s_value;
  logic        s_valid;
  logic        s_alarm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  level_alarm_controller dut (
    .clk(clk), .rst(rst), .number(number), .dp_list(dp_list), .btn0(btn0),
    .state(state), .value(value), .valid(valid), .alarm(alarm)
  );

  level_alarm_controller #(.VAL_W(24)) u_sat (
    .clk(clk), .rst(rst), .number(32'h99999999), .dp_list(8'h00), .btn0(1'b0),
    .state(s_state), .value(s_value), .valid(s_valid), .alarm(s_alarm)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic next_frame();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid && n < 40);
    check("frame_valid", valid, 1);
  endtask

  task automatic run_frame(input logic [31:0] num, input logic [7:0] dp);
    number  = num;
    dp_list = dp;
    next_frame();
  endtask

  task automatic measure_valid(input string tag);
    int   n;
    logic held;
    n    = 0;
    held = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!valid && (state !== 3'd0 || value !== 32'd0 || alarm !== 1'b0)) held = 1'b0;
    end while (!valid && n < 40);
    check({tag, "_latency"}, n, 12);
    check({tag, "_idle_hold"}, held, 1);
  endtask

  initial begin
    number  = 32'h08080706;
    dp_list = 8'h10;
    rst     = 1'b1;
    step(3);
    check("rst_state", state, 0);
    check("rst_value", value, 0);
    check("rst_valid", valid, 0);
    check("rst_alarm", alarm, 0);
    rst = 1'b0;
    measure_valid("first");
    check("first_value", value, 80807);
    check("first_state", state, 2);
    check("first_alarm", alarm, 0);
    check("sat_value", s_value, 16777215);
    check("sat_state", s_state, 3);
    check("sat_alarm", s_alarm, 1);

    run_frame(32'hFF020202, 8'h01);
    check("a1_value", value, 2020200);
    check("a1_state", state, 2);
    run_frame(32'hFF020202, 8'h01);
    check("a2_state", state, 3);
    check("a2_alarm", alarm, 1);
    run_frame(32'hFFFFFF02, 8'h01);
    check("l1_value", value, 200);
    check("l1_state", state, 3);
    run_frame(32'hFFFFFF02, 8'h01);
    check("l2_state", state, 4);
    check("l2_alarm", alarm, 1);
    btn0 = 1'b1;
    step(10);
    btn0 = 1'b0;
    step(2);
    check("ack_state", state, 1);
    check("ack_alarm", alarm, 0);
    next_frame();
    check("post_ack_state", state, 1);

    run_frame(32'h08080706, 8'h10);
    check("w1_state", state, 1);
    run_frame(32'h08080706, 8'h10);
    check("w2_state", state, 2);
    for (int i = 0; i < 4; i++) begin
      run_frame(32'h00049500, 8'h04);
      check("hyst_hold", state, 2);
    end
    check("hyst_value", value, 49500);
    run_frame(32'h00048900, 8'h04);
    check("drop1_state", state, 2);
    run_frame(32'h00048900, 8'h04);
    check("drop2_state", state, 1);
    check("drop2_value", value, 48900);
    run_frame(32'h08080706, 8'h10);
    run_frame(32'h08080706, 8'h10);
    check("rewarn_state", state, 2);
    for (int i = 0; i < 3; i++) begin
      run_frame(32'h00048900, 8'h04);
      check("alt_low", state, 2);
      run_frame(32'h00049500, 8'h04);
      check("alt_high", state, 2);
    end

    run_frame(32'h0A000000, 8'h01);
    check("f_nibble_state", state, 5);
    check("f_nibble_value", value, 49500);
    run_frame(32'h00000012, 8'h03);
    check("f_dp_state", state, 5);
    check("f_dp_value", value, 49500);
    run_frame(32'hF0FF0000, 8'h01);
    check("f_blank_state", state, 5);
    run_frame(32'hFFFFFF02, 8'h01);
    check("recover_state", state, 1);
    check("recover_value", value, 200);

    run_frame(32'hFF020202, 8'h01);
    run_frame(32'hFF020202, 8'h01);
    check("b_alarm_state", state, 3);
    btn0 = 1'b1;
    step(3);
    btn0 = 1'b0;
    step(8);
    check("glitch_alarm", alarm, 1);
    check("glitch_state", state, 3);
    btn0 = 1'b1;
    step(8);
    btn0 = 1'b0;
    step(2);
    check("silence_state", state, 3);
    check("silence_alarm", alarm, 0);
    next_frame();
    run_frame(32'hFFFFFF02, 8'h01);
    check("sil_d1_state", state, 3);
    run_frame(32'hFFFFFF02, 8'h01);
    check("sil_d2_state", state, 1);
    check("sil_d2_alarm", alarm, 0);

    step(4);
    rst = 1'b1;
    step(1);
    check("mid_rst_state", state, 0);
    check("mid_rst_value", value, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_alarm", alarm, 0);
    rst = 1'b0;
    measure_valid("restart");
    check("restart_value", value, 200);
    check("restart_state", state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/level_alarm_controller.md
# level_alarm_controller

Parametrised successor to the water-detection `controller`. It converts an N-digit nibble-packed BCD display value plus a decimal-point mask into a scaled binary value. It classifies that value against warning and alarm thresholds, with hysteresis and frame persistence, and latches alarms until a debounced `btn0` acknowledge. It sits between the measurement/display path (which supplies `number` and `dp_list`) and the indicator/buzzer logic (which consumes `state` and `alarm`).

## Interface
- `DIGITS`, 8: number of BCD digits; `number` is 4·DIGITS bits wide and `dp_list` is DIGITS bits wide.
- `FRAC`, 2: fractional decimal digits kept in `value`, so `value` = floor(reading·10^FRAC).
- `VAL_W`, 32: width of `value`.
- `WARN_TH`, 50000: warning threshold, in scaled units.
- `ALARM_TH`, 100000: alarm threshold, in scaled units; must exceed `WARN_TH`.
- `HYST`, 1000: hysteresis, in scaled units; must be less than `WARN_TH`.
- `PERSIST`, 2: consecutive frames needed for any class change after the first classification.
- `DEBOUNCE`, 4: number of cycles the synchronised `btn0` must stay high to count as an acknowledge.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `number` in 4·DIGITS: digit i is at [4i+3:4i], with digit 0 rightmost; 0xF means blank.
- `dp_list` in DIGITS: bit k set means digit k is the units digit; all-zero means k=0.
- `btn0` in 1: asynchronous acknowledge button.
- `state` out 3: 0 IDLE, 1 NORMAL, 2 WARN, 3 ALARM, 4 LATCHED, 5 FAULT.
- `value` out VAL_W: last valid scaled reading.
- `valid` out 1: one-cycle pulse at the end of each frame.
- `alarm` out 1: buzzer request.

## Operation
- **Frame timing:** frames run back-to-back, each F = DIGITS+FRAC+2 cycles.
  - CAPTURE (1 cycle): register `number` and `dp_list`, then validate them.
  - ACCUM (DIGITS+FRAC cycles): Horner evaluation, acc = acc·10 + d.
  - Positions run p = DIGITS−1 down to −FRAC.
  - Positions p < 0 contribute d = 0; blanks contribute 0.
  - Only positions p ≥ k−FRAC are accumulated; lower positions are idle cycles, so extra fractional digits are truncated.
  - CLASSIFY (1 cycle): update `state`, `value` and `valid`.
- **Saturation:** if acc would exceed 2^VAL_W−1, it clamps at 2^VAL_W−1 for the rest of the frame.
- **Invalid frame:** any of the following makes a frame invalid.
  - A nibble in 0xA–0xE.
  - A blank below a non-blank digit.
  - All digits blank.
  - More than one `dp_list` bit set.
  - A blank at position k.
- **Invalid frame result:** `state` goes to FAULT at CLASSIFY, `value` is held and the persistence counter is cleared.
- **Target class T:**
  - ALARM if value ≥ ALARM_TH.
  - Otherwise WARN if value ≥ WARN_TH.
  - Otherwise NORMAL.
- **Hysteresis:**
  - While in ALARM, T stays ALARM unless value < ALARM_TH−HYST.
  - While in WARN, T stays at least WARN unless value < WARN_TH−HYST.
- **Immediate classification:** from IDLE or FAULT, the first valid frame sets `state` = T immediately, and a silenced flag clears.
- **Persistence:** otherwise, a counter increments each frame where T ≠ current class and the same T as the previous frame.
  - It resets to 1 when T changes and to 0 when T equals the current class.
  - The transition happens when the count reaches PERSIST.
- **ALARM de-escalation:**
  - If not silenced, ALARM goes to LATCHED.
  - If silenced, ALARM goes to T.
- **LATCHED:** moves to ALARM after PERSIST frames with T = ALARM; otherwise it waits for an acknowledge.
- **Acknowledge path:** `btn0` passes through a 2-flop synchroniser and a DEBOUNCE-cycle stability counter. A 1-cycle `ack` pulse is produced on each debounced rising level.
- **Acknowledge effect:**
  - ack in ALARM sets silenced.
  - ack in LATCHED sets `state` = the last frame's T (NORMAL or WARN) on the next cycle.
  - ack in any other state is ignored.
- **alarm output:** `alarm` = (state==ALARM && !silenced) || state==LATCHED. Silenced clears whenever ALARM is entered.

## Timing
- **Reset:** all outputs are registered. The reset values are `state`=0 (IDLE), `value`=0, `valid`=0, `alarm`=0; the counters, synchroniser and silenced flag are also cleared.
- **First frame:** CAPTURE is the first cycle after `rst` deasserts. The first `valid` pulse comes F cycles later (12 with the defaults).
- **Reset mid-frame:** the partial frame is discarded and the frame restarts from CAPTURE.
- **Input sampling:** inputs are sampled only in CAPTURE; changes during ACCUM take effect in the next frame.
- **Output update:** `state`, `value` and `alarm` change in the cycle `valid` is high, or in the cycle after an `ack`.
- **Ack latency:** from the first high sample of `btn0` to `ack` is 2+DEBOUNCE cycles.
- **Ack coinciding with CLASSIFY:** the ack is applied first, and classification then runs on the resulting state.
- **Debounce glitch:** a `btn0` high pulse shorter than DEBOUNCE cycles produces no `ack`.

## Test plan
All scenarios use the default parameters.
1. **Reset:** assert `rst` for 3 cycles, then release -> `state`=0, `alarm`=0, `value`=0 until the first `valid` at cycle 12.
2. **First conversion:** `number`=0x08080706, `dp_list`=0x10 -> `value`=80807 and `state`=WARN at the first CLASSIFY (no persistence from IDLE).
3. **Alarm, latch and acknowledge:**
   - Apply 0xFF020202 / 0x01 -> `value`=2020200; after 2 frames `state`=ALARM and `alarm`=1.
   - Then apply 0xFFFFFF02 / 0x01 -> `value`=200; after 2 frames `state`=LATCHED and `alarm`=1.
   - Hold `btn0`=1 for 10 cycles -> `state`=NORMAL and `alarm`=0.
4. **Hysteresis:**
   - In WARN, apply 0x00049500 / 0x04 (49500) for 4 frames -> stays WARN.
   - Then apply 0x00048900 / 0x04 (48900) -> NORMAL after exactly 2 frames.
   - Alternating 48900 and 49500 frames never leaves WARN.
5. **Faults:**
   - 0x0A000000 -> FAULT with `value` held.
   - `dp_list`=0x03 -> FAULT.
   - 0xF0FF0000 (embedded blank) -> FAULT.
   - A following valid 0xFFFFFF02 / 0x01 -> NORMAL immediately.
6. **Edge cases:**
   - With VAL_W=24, 0x99999999 / 0x00 -> `value`=16777215.
   - `rst` pulsed mid-ACCUM -> outputs return to reset values and the next `valid` comes 12 cycles after release.
   - A 3-cycle `btn0` pulse in ALARM -> `alarm` stays 1.
